// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter sequencing states: idle, or waiting for the bus ack of one port
  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbDmWait = 2'd1,
    ArbIfWait = 2'd2
  } arbState_e;

  // Identifies which pipeline port owns the bus
  typedef enum logic {
    ArbDataPort = 1'b0,
    ArbInstPort = 1'b1
  } arbPort_e;

  // Instruction fetches always read a full word
  localparam logic [3:0] SelAllBytes = 4'b1111;

  // Which port a wait state belongs to (ArbIdle maps to the data port but is
  // always qualified by a non-idle check at the call site)
  function automatic arbPort_e portOf(input arbState_e s);
    return (s == ArbIfWait) ? ArbInstPort : ArbDataPort;
  endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// Per-port bookkeeping: held read data, served (done) flag, flush discard flag
// and the stall request seen by the pipeline.
module mem_arb_slot
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              busy_i,
  input  logic              ack_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              done_o,
  output logic              stall_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              discard_q, discard_d;

  // Next-state for held data and flags; flush outranks a completing ack
  always_comb begin
    data_d    = data_q;
    done_d    = done_q;
    discard_d = discard_q;
    if (ack_i) begin
      if (load_i && !discard_q && !flush_i) begin
        data_d = data_i;
      end
      discard_d = 1'b0;
    end else if (busy_i && flush_i) begin
      discard_d = 1'b1;
    end
    if (flush_i) begin
      done_d = 1'b0;
    end else if (ack_i && !discard_q) begin
      done_d = 1'b1;
    end else if (done_q && !hold_i) begin
      done_d = 1'b0;
    end
  end

  // Slot registers, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      done_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      done_q    <= done_d;
      discard_q <= discard_d;
    end
  end

  assign data_o  = data_q;
  assign done_o  = done_q;
  assign stall_o = ce_i & ~done_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between the IF and MEM pipeline ports.
// Data accesses win ties because they belong to the older instruction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stall_o,
  input  logic              if_hold_i,
  input  logic              dm_ce_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_sel_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic [DATA_W-1:0] dm_data_o,
  output logic              dm_stall_o,
  input  logic              dm_hold_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
);

  arbState_e         state_q, state_d;
  logic              busReq_q, busReq_d;
  logic              busWe_q, busWe_d;
  logic [3:0]        busSel_q, busSel_d;
  logic [ADDR_W-1:0] busAddr_q, busAddr_d;
  logic [DATA_W-1:0] busData_q, busData_d;

  logic ifDone, dmDone;
  logic ifPend, dmPend;
  logic issueIf, issueDm;
  logic waiting, ifBusy, dmBusy;

  assign dmPend  = dm_ce_i & ~dmDone;
  assign ifPend  = if_ce_i & ~ifDone & ~flush_i;
  assign waiting = (state_q != ArbIdle);
  assign ifBusy  = waiting && (portOf(state_q) == ArbInstPort);
  assign dmBusy  = waiting && (portOf(state_q) == ArbDataPort);

  // Next-state and bus field latching; on ack the other port chains straight on
  always_comb begin
    state_d   = state_q;
    busReq_d  = busReq_q;
    busWe_d   = busWe_q;
    busSel_d  = busSel_q;
    busAddr_d = busAddr_q;
    busData_d = busData_q;
    issueIf   = 1'b0;
    issueDm   = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (dmPend) begin
          issueDm = 1'b1;
        end else if (ifPend) begin
          issueIf = 1'b1;
        end
      end
      ArbDmWait: begin
        if (bus_ack_i) begin
          if (ifPend) begin
            issueIf = 1'b1;
          end else begin
            state_d  = ArbIdle;
            busReq_d = 1'b0;
          end
        end
      end
      ArbIfWait: begin
        if (bus_ack_i) begin
          if (dmPend) begin
            issueDm = 1'b1;
          end else begin
            state_d  = ArbIdle;
            busReq_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = ArbIdle;
        busReq_d = 1'b0;
      end
    endcase
    if (issueDm) begin
      state_d   = ArbDmWait;
      busReq_d  = 1'b1;
      busWe_d   = dm_we_i;
      busSel_d  = dm_sel_i;
      busAddr_d = dm_addr_i;
      busData_d = dm_data_i;
    end
    if (issueIf) begin
      state_d   = ArbIfWait;
      busReq_d  = 1'b1;
      busWe_d   = 1'b0;
      busSel_d  = SelAllBytes;
      busAddr_d = if_addr_i;
      busData_d = '0;
    end
  end

  // State and frozen bus fields; reset abandons any request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ArbIdle;
      busReq_q  <= 1'b0;
      busWe_q   <= 1'b0;
      busSel_q  <= '0;
      busAddr_q <= '0;
      busData_q <= '0;
    end else begin
      state_q   <= state_d;
      busReq_q  <= busReq_d;
      busWe_q   <= busWe_d;
      busSel_q  <= busSel_d;
      busAddr_q <= busAddr_d;
      busData_q <= busData_d;
    end
  end

  assign bus_req_o  = busReq_q;
  assign bus_we_o   = busWe_q;
  assign bus_sel_o  = busSel_q;
  assign bus_addr_o = busAddr_q;
  assign bus_data_o = busData_q;

  mem_arb_slot #(.DATA_W(DATA_W)) ifSlot (
    .clk     (clk),
    .rst     (rst),
    .ce_i    (if_ce_i),
    .hold_i  (if_hold_i),
    .flush_i (flush_i),
    .busy_i  (ifBusy),
    .ack_i   (ifBusy & bus_ack_i),
    .load_i  (1'b1),
    .data_i  (bus_data_i),
    .data_o  (if_data_o),
    .done_o  (ifDone),
    .stall_o (if_stall_o)
  );

  mem_arb_slot #(.DATA_W(DATA_W)) dmSlot (
    .clk     (clk),
    .rst     (rst),
    .ce_i    (dm_ce_i),
    .hold_i  (dm_hold_i),
    .flush_i (flush_i),
    .busy_i  (dmBusy),
    .ack_i   (dmBusy & bus_ack_i),
    .load_i  (~busWe_q),
    .data_i  (bus_data_i),
    .data_o  (dm_data_o),
    .done_o  (dmDone),
    .stall_o (dm_stall_o)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a configurable-wait slave, a scoreboard of
// expected bus transactions, and directed pipeline scenarios.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i, if_hold_i, dm_ce_i, dm_we_i, dm_hold_i, flush_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_data_i;
  logic [31:0] if_data_o, dm_data_o;
  logic        if_stall_o, dm_stall_o;
  logic        bus_req_o, bus_we_o, bus_ack_i;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_data_o, bus_data_i;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   waitCycles = 0;
  int   waitCnt;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce_i    (if_ce_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_stall_o (if_stall_o),
    .if_hold_i  (if_hold_i),
    .dm_ce_i    (dm_ce_i),
    .dm_we_i    (dm_we_i),
    .dm_sel_i   (dm_sel_i),
    .dm_addr_i  (dm_addr_i),
    .dm_data_i  (dm_data_i),
    .dm_data_o  (dm_data_o),
    .dm_stall_o (dm_stall_o),
    .dm_hold_i  (dm_hold_i),
    .flush_i    (flush_i),
    .bus_req_o  (bus_req_o),
    .bus_we_o   (bus_we_o),
    .bus_sel_o  (bus_sel_o),
    .bus_addr_o (bus_addr_o),
    .bus_data_o (bus_data_o),
    .bus_data_i (bus_data_i),
    .bus_ack_i  (bus_ack_i)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Memory contents seen by the slave
  function automatic logic [31:0] memFn(input logic [31:0] a);
    case (a)
      32'h100: memFn = 32'h3C010101;
      32'h300: memFn = 32'h12345678;
      default: memFn = {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  assign bus_data_i = memFn(bus_addr_o);
  assign bus_ack_i  = bus_req_o && (waitCnt == waitCycles);

  // Slave wait-state counter, restarted after every ack
  always @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= 0;
    else if (!bus_req_o || bus_ack_i) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Every cycle with a live request is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst && bus_req_o) begin
      checkOutput("txnQueued", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        checkOutput("txnAddr", bus_addr_o, expQ[0].addr);
        checkOutput("txnWe", 32'(bus_we_o), 32'(expQ[0].we));
        checkOutput("txnSel", 32'(bus_sel_o), 32'(expQ[0].sel));
        if (expQ[0].we) checkOutput("txnWdata", bus_data_o, expQ[0].wdata);
        if (bus_ack_i) void'(expQ.pop_front());
      end
    end
  end

  task automatic pushTxn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.sel = sel; t.addr = addr; t.wdata = wdata;
    expQ.push_back(t);
  endtask

  task automatic applyStimulus(input logic ifCe, input logic [31:0] ifAddr, input logic ifHold,
                               input logic dmCe, input logic dmWe, input logic [3:0] dmSel,
                               input logic [31:0] dmAddr, input logic [31:0] dmData,
                               input logic dmHold, input logic flush);
    if_ce_i = ifCe; if_addr_i = ifAddr; if_hold_i = ifHold;
    dm_ce_i = dmCe; dm_we_i = dmWe; dm_sel_i = dmSel;
    dm_addr_i = dmAddr; dm_data_i = dmData; dm_hold_i = dmHold; flush_i = flush;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleOut();
    @(negedge clk);
  endtask

  // Guard against a hung simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    rst = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    sampleOut();
    checkOutput("rstBusReq", 32'(bus_req_o), 0);
    checkOutput("rstBusAddr", bus_addr_o, 0);
    checkOutput("rstBusWe", 32'(bus_we_o), 0);
    checkOutput("rstIfData", if_data_o, 0);
    checkOutput("rstDmData", dm_data_o, 0);
    nextCycle();
    rst = 1'b1;
    repeat (2) nextCycle();

    // IF only, zero-wait slave
    $display("[TB] IF fetch, zero-wait");
    nextCycle();
    applyStimulus(1, 32'h100, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    pushTxn(0, 4'hF, 32'h100, 0);
    sampleOut();
    checkOutput("ifC0Stall", 32'(if_stall_o), 1);
    checkOutput("ifC0Req", 32'(bus_req_o), 0);
    nextCycle(); sampleOut();
    checkOutput("ifC1Req", 32'(bus_req_o), 1);
    checkOutput("ifC1Addr", bus_addr_o, 32'h100);
    checkOutput("ifC1Stall", 32'(if_stall_o), 1);
    nextCycle(); sampleOut();
    checkOutput("ifC2Stall", 32'(if_stall_o), 0);
    checkOutput("ifC2Data", if_data_o, 32'h3C010101);
    nextCycle(); idleInputs();
    repeat (2) nextCycle();

    // Simultaneous requests, one-wait slave: store first, fetch chained
    $display("[TB] simultaneous IF and DM");
    waitCycles = 1;
    nextCycle();
    applyStimulus(1, 32'h104, 1, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF, 1, 0);
    pushTxn(1, 4'b0011, 32'h200, 32'hDEADBEEF);
    pushTxn(0, 4'hF, 32'h104, 0);
    sampleOut();
    checkOutput("simC0DmStall", 32'(dm_stall_o), 1);
    checkOutput("simC0IfStall", 32'(if_stall_o), 1);
    nextCycle(); sampleOut();
    checkOutput("simC1Req", 32'(bus_req_o), 1);
    checkOutput("simC1Addr", bus_addr_o, 32'h200);
    checkOutput("simC1We", 32'(bus_we_o), 1);
    nextCycle(); sampleOut();
    checkOutput("simC2DmStall", 32'(dm_stall_o), 1);
    nextCycle(); sampleOut();
    checkOutput("simC3NoBubble", 32'(bus_req_o), 1);
    checkOutput("simC3Addr", bus_addr_o, 32'h104);
    checkOutput("simC3DmStall", 32'(dm_stall_o), 0);
    checkOutput("simC3IfStall", 32'(if_stall_o), 1);
    nextCycle(); sampleOut();
    checkOutput("simC4IfStall", 32'(if_stall_o), 1);
    nextCycle(); sampleOut();
    checkOutput("simC5IfStall", 32'(if_stall_o), 0);
    checkOutput("simC5IfData", if_data_o, memFn(32'h104));
    checkOutput("simC5Req", 32'(bus_req_o), 0);
    nextCycle(); idleInputs();
    repeat (2) nextCycle();

    // Load completes while the MEM stage holds
    $display("[TB] hold");
    waitCycles = 0;
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 1, 0);
    pushTxn(0, 4'hF, 32'h300, 0);
    nextCycle(); sampleOut();
    checkOutput("holdC1Addr", bus_addr_o, 32'h300);
    nextCycle(); sampleOut();
    checkOutput("holdC2Stall", 32'(dm_stall_o), 0);
    checkOutput("holdC2Data", dm_data_o, 32'h12345678);
    for (int i = 0; i < 2; i++) begin
      nextCycle(); sampleOut();
      checkOutput("holdNoReissue", 32'(bus_req_o), 0);
      checkOutput("holdData", dm_data_o, 32'h12345678);
      checkOutput("holdStall", 32'(dm_stall_o), 0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 4'hF, 32'h304, 0, 0, 0);
    pushTxn(0, 4'hF, 32'h304, 0);
    sampleOut();
    checkOutput("holdC5Stall", 32'(dm_stall_o), 0);
    nextCycle(); sampleOut();
    checkOutput("holdC6Stall", 32'(dm_stall_o), 1);
    nextCycle(); sampleOut();
    checkOutput("holdC7Req", 32'(bus_req_o), 1);
    nextCycle(); sampleOut();
    checkOutput("holdC8Stall", 32'(dm_stall_o), 0);
    checkOutput("holdC8Data", dm_data_o, memFn(32'h304));
    nextCycle(); idleInputs();
    repeat (2) nextCycle();

    // Flush while a fetch waits on a three-wait slave
    $display("[TB] flush in flight");
    waitCycles = 3;
    nextCycle();
    applyStimulus(1, 32'h180, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    pushTxn(0, 4'hF, 32'h180, 0);
    pushTxn(0, 4'hF, 32'h180, 0);
    nextCycle(); sampleOut();
    checkOutput("flC1Req", 32'(bus_req_o), 1);
    nextCycle();
    applyStimulus(1, 32'h180, 0, 0, 0, 4'h0, 0, 0, 0, 1);
    sampleOut();
    checkOutput("flC2Stall", 32'(if_stall_o), 1);
    nextCycle();
    applyStimulus(1, 32'h180, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    sampleOut();
    checkOutput("flC3Stall", 32'(if_stall_o), 1);
    checkOutput("flC3Req", 32'(bus_req_o), 1);
    nextCycle(); sampleOut();
    checkOutput("flC4Ack", 32'(bus_ack_i), 1);
    nextCycle(); sampleOut();
    checkOutput("flC5Stall", 32'(if_stall_o), 1);
    checkOutput("flC5Req", 32'(bus_req_o), 0);
    nextCycle(); sampleOut();
    checkOutput("flC6Reissue", 32'(bus_req_o), 1);
    repeat (3) nextCycle();
    nextCycle(); sampleOut();
    checkOutput("flC10Stall", 32'(if_stall_o), 0);
    checkOutput("flC10Data", if_data_o, memFn(32'h180));
    nextCycle(); idleInputs();
    repeat (2) nextCycle();

    // Slow slave: port inputs change while the store waits
    $display("[TB] slow slave");
    waitCycles = 5;
    nextCycle();
    applyStimulus(0, 0, 0, 1, 1, 4'b1100, 32'h400, 32'h0BADF00D, 1, 0);
    pushTxn(1, 4'b1100, 32'h400, 32'h0BADF00D);
    nextCycle(); sampleOut();
    checkOutput("slowC1Req", 32'(bus_req_o), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 1, 4'hF, 32'h4FC, 32'hFFFFFFFF, 1, 0);
    nextCycle();
    nextCycle(); sampleOut();
    checkOutput("slowC4Addr", bus_addr_o, 32'h400);
    checkOutput("slowC4Data", bus_data_o, 32'h0BADF00D);
    checkOutput("slowC4Sel", 32'(bus_sel_o), 32'hC);
    checkOutput("slowC4Stall", 32'(dm_stall_o), 1);
    repeat (2) nextCycle();
    nextCycle(); sampleOut();
    checkOutput("slowC7Stall", 32'(dm_stall_o), 0);
    checkOutput("slowC7StoreNoCapture", dm_data_o, memFn(32'h304));
    checkOutput("slowC7Req", 32'(bus_req_o), 0);
    nextCycle(); idleInputs();
    repeat (2) nextCycle();

    // Asynchronous reset in the middle of a data wait
    $display("[TB] async reset");
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 4'hF, 32'h500, 0, 0, 0);
    pushTxn(0, 4'hF, 32'h500, 0);
    nextCycle(); sampleOut();
    checkOutput("arC1Req", 32'(bus_req_o), 1);
    nextCycle();
    #2 rst = 1'b0;
    #1;
    checkOutput("arBusReq", 32'(bus_req_o), 0);
    checkOutput("arBusAddr", bus_addr_o, 0);
    checkOutput("arBusWe", 32'(bus_we_o), 0);
    checkOutput("arBusSel", 32'(bus_sel_o), 0);
    checkOutput("arBusData", bus_data_o, 0);
    checkOutput("arIfData", if_data_o, 0);
    checkOutput("arDmData", dm_data_o, 0);
    expQ.delete();
    idleInputs();
    waitCycles = 0;
    nextCycle();
    rst = 1'b1;
    sampleOut();
    checkOutput("arIdleReq", 32'(bus_req_o), 0);
    nextCycle();
    applyStimulus(1, 32'h100, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    pushTxn(0, 4'hF, 32'h100, 0);
    nextCycle(); sampleOut();
    checkOutput("arFetchReq", 32'(bus_req_o), 1);
    nextCycle(); sampleOut();
    checkOutput("arFetchStall", 32'(if_stall_o), 0);
    checkOutput("arFetchData", if_data_o, 32'h3C010101);
    nextCycle(); idleInputs();
    repeat (2) nextCycle();

    checkOutput("queueDrained", 32'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
